// File: rtl/escalonador_rr.sv
// Round-robin scheduler: alternates the CPU between the SO (id 0) and the next
// ready user process, enforcing a programmable quantum and context strobes.
module escalonador_rr #(
  parameter int N_PROC = 3,
  parameter int ID_W   = 2,
  parameter int QW     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              passo,
  input  logic              HALT,
  input  logic              fim_so,
  input  logic              carrega,
  input  logic [ID_W-1:0]   carrega_id,
  input  logic [QW-1:0]     quantum,
  output logic [ID_W-1:0]   id_proc,
  output logic [ID_W-1:0]   id_proc_atual,
  output logic              Sel_BIOS,
  output logic              Set_ctx,
  output logic              Salva_ctx,
  output logic              quantum_over,
  output logic              ocioso,
  output logic [N_PROC-1:0] pronto
);

  typedef enum logic [1:0] {ST_SO, ST_CARREGA, ST_EXEC, ST_SALVA} state_t;

  state_t            state_q;
  logic [QW-1:0]     cnt_q, quantum_q, quantum_eff;
  logic [ID_W-1:0]   id_proc_q, atual_q, next_id_d;
  logic [ID_W:0]     cand;
  logic [N_PROC-1:0] pronto_q, pronto_d;
  logic              sel_bios_q, set_ctx_q, salva_ctx_q, quantum_over_q, ocioso_q;

  assign quantum_eff = (quantum == '0) ? QW'(1) : quantum;

  // A load request on the same edge as a HALT of that process wins.
  genvar gi;
  generate
    for (gi = 0; gi < N_PROC; gi++) begin : g_pronto
      assign pronto_d[gi] =
        (carrega && carrega_id == ID_W'(gi + 1)) ? 1'b1 :
        (state_q == ST_EXEC && HALT && atual_q == ID_W'(gi + 1)) ? 1'b0 :
        pronto_q[gi];
    end
  endgenerate

  // Scan offsets from farthest to nearest so the nearest ready id after the
  // current one overwrites the others; the current id itself is offset N_PROC.
  always_comb begin
    next_id_d = '0;
    cand      = '0;
    for (int off = N_PROC; off >= 1; off--) begin
      cand = {1'b0, atual_q} + (ID_W+1)'(off);
      if (cand > (ID_W+1)'(N_PROC)) cand = cand - (ID_W+1)'(N_PROC);
      for (int i = 0; i < N_PROC; i++) begin
        if (cand == (ID_W+1)'(i + 1) && pronto_q[i]) next_id_d = cand[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_SO;
      cnt_q          <= '0;
      quantum_q      <= '0;
      id_proc_q      <= '0;
      atual_q        <= '0;
      pronto_q       <= '0;
      sel_bios_q     <= 1'b1;
      set_ctx_q      <= 1'b0;
      salva_ctx_q    <= 1'b0;
      quantum_over_q <= 1'b0;
      ocioso_q       <= 1'b1;
    end else begin
      pronto_q       <= pronto_d;
      set_ctx_q      <= 1'b0;
      salva_ctx_q    <= 1'b0;
      quantum_over_q <= 1'b0;
      ocioso_q       <= 1'b0;
      case (state_q)
        ST_SO: begin
          if (fim_so && |pronto_q) begin
            state_q    <= ST_CARREGA;
            set_ctx_q  <= 1'b1;
            sel_bios_q <= 1'b0;
            id_proc_q  <= next_id_d;
            atual_q    <= next_id_d;
            cnt_q      <= '0;
          end else begin
            ocioso_q <= ~|pronto_d;
          end
        end
        ST_CARREGA: begin
          state_q   <= ST_EXEC;
          quantum_q <= quantum_eff;
          cnt_q     <= '0;
        end
        ST_EXEC: begin
          if (HALT) begin
            state_q    <= ST_SO;
            sel_bios_q <= 1'b1;
            id_proc_q  <= '0;
            ocioso_q   <= ~|pronto_d;
          end else if (passo) begin
            if (cnt_q == quantum_q - 1'b1) begin
              state_q        <= ST_SALVA;
              quantum_over_q <= 1'b1;
              salva_ctx_q    <= 1'b1;
              sel_bios_q     <= 1'b1;
              id_proc_q      <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_SALVA: begin
          state_q  <= ST_SO;
          ocioso_q <= ~|pronto_d;
        end
        default: state_q <= ST_SO;
      endcase
    end
  end

  assign id_proc       = id_proc_q;
  assign id_proc_atual = atual_q;
  assign Sel_BIOS      = sel_bios_q;
  assign Set_ctx       = set_ctx_q;
  assign Salva_ctx     = salva_ctx_q;
  assign quantum_over  = quantum_over_q;
  assign ocioso        = ocioso_q;
  assign pronto        = pronto_q;

endmodule

// File: tb/tb_escalonador_rr.sv
// Directed bench for escalonador_rr; ID_W is widened to 3 so out-of-range ids
// such as N_PROC+1 can be driven.
module tb_escalonador_rr;

  logic       clk = 1'b0;
  logic       reset, passo, HALT, fim_so, carrega;
  logic [2:0] carrega_id;
  logic [7:0] quantum;
  logic [2:0] id_proc, id_proc_atual, pronto;
  logic       Sel_BIOS, Set_ctx, Salva_ctx, quantum_over, ocioso;

  int n_tests = 0;
  int n_fail  = 0;

  escalonador_rr #(.N_PROC(3), .ID_W(3), .QW(8)) dut (
    .clk(clk), .reset(reset), .passo(passo), .HALT(HALT), .fim_so(fim_so),
    .carrega(carrega), .carrega_id(carrega_id), .quantum(quantum),
    .id_proc(id_proc), .id_proc_atual(id_proc_atual), .Sel_BIOS(Sel_BIOS),
    .Set_ctx(Set_ctx), .Salva_ctx(Salva_ctx), .quantum_over(quantum_over),
    .ocioso(ocioso), .pronto(pronto)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] id);
    carrega = 1'b1; carrega_id = id;
    tick();
    carrega = 1'b0; carrega_id = '0;
  endtask

  // Full slice with passo held high; q is the effective quantum.
  task automatic run_slice(input logic [2:0] id, input int q);
    passo = 1'b1;
    fim_so = 1'b1;
    tick();
    fim_so = 1'b0;
    check("carrega_set_ctx", Set_ctx, 1);
    check("carrega_id_proc", id_proc, id);
    check("carrega_atual", id_proc_atual, id);
    check("carrega_sel_bios", Sel_BIOS, 0);
    tick();
    check("exec_set_ctx_low", Set_ctx, 0);
    check("exec_id_proc", id_proc, id);
    for (int i = 0; i < q - 1; i++) begin
      tick();
      check("exec_no_qover", quantum_over, 0);
      check("exec_sel_bios", Sel_BIOS, 0);
    end
    tick();
    check("salva_qover", quantum_over, 1);
    check("salva_ctx", Salva_ctx, 1);
    check("salva_id_proc", id_proc, 0);
    check("salva_sel_bios", Sel_BIOS, 1);
    tick();
    check("so_qover_low", quantum_over, 0);
    check("so_salva_low", Salva_ctx, 0);
    check("so_sel_bios", Sel_BIOS, 1);
    check("so_atual", id_proc_atual, id);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; passo = 0; HALT = 0; fim_so = 0; carrega = 0;
    carrega_id = '0; quantum = 8'd4;
    #3;
    check("rst_state_id_proc", id_proc, 0);
    check("rst_atual", id_proc_atual, 0);
    check("rst_pronto", pronto, 0);
    check("rst_sel_bios", Sel_BIOS, 1);
    check("rst_ocioso", ocioso, 1);
    check("rst_pulses", {Set_ctx, Salva_ctx, quantum_over}, 0);
    #9;
    reset = 1'b0;
    tick();

    // Round-robin over three ready processes
    load(3'd1); check("pronto_1", pronto, 3'b001); check("not_idle", ocioso, 0);
    load(3'd2); check("pronto_12", pronto, 3'b011);
    load(3'd3); check("pronto_123", pronto, 3'b111);
    run_slice(3'd1, 4);
    run_slice(3'd2, 4);
    run_slice(3'd3, 4);
    run_slice(3'd1, 4);

    // Sole ready process rescheduled
    do_reset();
    load(3'd2);
    run_slice(3'd2, 4);
    run_slice(3'd2, 4);
    fim_so = 1'b1; tick(); fim_so = 1'b0;
    check("halt2_carrega", id_proc, 2);
    tick();
    HALT = 1'b1; tick(); HALT = 1'b0;
    check("halt2_pronto", pronto, 0);
    check("halt2_ocioso", ocioso, 1);
    fim_so = 1'b1; tick(); fim_so = 1'b0;
    check("idle_no_set_ctx", Set_ctx, 0);
    check("idle_id_proc", id_proc, 0);
    check("idle_ocioso", ocioso, 1);
    check("idle_sel_bios", Sel_BIOS, 1);

    // HALT in 2nd EXEC cycle
    do_reset();
    load(3'd1);
    passo = 1'b1;
    fim_so = 1'b1; tick(); fim_so = 1'b0;
    tick();
    tick();
    check("halt_pre_exec", Sel_BIOS, 0);
    HALT = 1'b1; tick(); HALT = 1'b0;
    check("halt_pronto", pronto, 0);
    check("halt_no_salva", Salva_ctx, 0);
    check("halt_no_qover", quantum_over, 0);
    check("halt_id_proc", id_proc, 0);
    check("halt_sel_bios", Sel_BIOS, 1);
    tick();
    check("halt_no_salva_late", Salva_ctx, 0);

    // HALT coincides with the final passo of a 2-instruction slice
    quantum = 8'd2;
    load(3'd1);
    fim_so = 1'b1; tick(); fim_so = 1'b0;
    tick();
    tick();
    HALT = 1'b1; tick(); HALT = 1'b0;
    check("halt_exp_qover", quantum_over, 0);
    check("halt_exp_salva", Salva_ctx, 0);
    check("halt_exp_pronto", pronto, 0);

    // carrega of the same id wins over HALT
    load(3'd1);
    fim_so = 1'b1; tick(); fim_so = 1'b0;
    tick();
    HALT = 1'b1; carrega = 1'b1; carrega_id = 3'd1;
    tick();
    HALT = 1'b0; carrega = 1'b0; carrega_id = '0;
    check("carrega_wins_pronto", pronto, 3'b001);
    check("carrega_wins_sel", Sel_BIOS, 1);

    // quantum 0 behaves as 1
    quantum = 8'd0;
    run_slice(3'd1, 1);

    // quantum 2 with passo toggling 1,0,1
    quantum = 8'd2;
    fim_so = 1'b1; tick(); fim_so = 1'b0;
    tick();
    passo = 1'b1; tick();
    check("toggle_p1", quantum_over, 0);
    passo = 1'b0; tick();
    check("toggle_p0", quantum_over, 0);
    check("toggle_p0_exec", Sel_BIOS, 0);
    passo = 1'b1; tick();
    check("toggle_expire", quantum_over, 1);
    check("toggle_salva", Salva_ctx, 1);
    tick();

    // Asynchronous reset mid-EXEC
    quantum = 8'd4;
    fim_so = 1'b1; tick(); fim_so = 1'b0;
    tick();
    check("mid_exec_id", id_proc, 1);
    #2 reset = 1'b1;
    #1;
    check("async_id_proc", id_proc, 0);
    check("async_atual", id_proc_atual, 0);
    check("async_pronto", pronto, 0);
    check("async_sel_bios", Sel_BIOS, 1);
    check("async_ocioso", ocioso, 1);
    #1 reset = 1'b0;
    tick();
    check("after_rst_no_salva", Salva_ctx, 0);
    check("after_rst_no_qover", quantum_over, 0);

    // Out-of-range ids ignored
    load(3'd0);
    check("load_id0", pronto, 0);
    load(3'd4);
    check("load_id4", pronto, 0);
    load(3'd7);
    check("load_id7", pronto, 0);
    check("load_bad_ocioso", ocioso, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
